// File: rtl/downstream_req_gen_if.sv
// Update/request bus of downstream_req_gen: upstream update handshake plus the
// downstream RAM write-request handshake and FIFO occupancy.
interface downstream_req_gen_if #(
  parameter int CLIENT_W = 5,
  parameter int AMOUNT_W = 16,
  parameter int DEPTH    = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                in_valid;
  logic [CLIENT_W-1:0] in_client_id;
  logic [AMOUNT_W-1:0] in_amount;
  logic                in_ready;
  logic                req_valid;
  logic                req_ready;
  logic [CLIENT_W-1:0] req_wrindex;
  logic [AMOUNT_W-1:0] req_amount;
  logic                req_we;
  logic [LVL_W-1:0]    fifo_level;

  // master: the environment producing updates and consuming requests
  modport master (
    output in_valid, in_client_id, in_amount, req_ready,
    input  in_ready, req_valid, req_wrindex, req_amount, req_we, fifo_level
  );

  // slave: the request generator itself
  modport slave (
    input  in_valid, in_client_id, in_amount, req_ready,
    output in_ready, req_valid, req_wrindex, req_amount, req_we, fifo_level
  );
endinterface

// File: rtl/downstream_req_gen.sv
// Per-client change filter feeding a small request FIFO towards a downstream RAM.
// Optional DS_DUP_CNT_EN adds a saturating count of unchanged (duplicate) updates.
module downstream_req_gen #(
  parameter int CLIENT_W = 5,
  parameter int AMOUNT_W = 16,
  parameter int DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  downstream_req_gen_if.slave  bus
`ifdef DS_DUP_CNT_EN
  ,
  output logic [15:0]          dup_cnt
`endif
);

  localparam int NUM_CLIENTS = 1 << CLIENT_W;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int LVL_W       = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Shadow table: valid bits are reset, amounts are not
  logic [NUM_CLIENTS-1:0] shadow_valid;
  logic [AMOUNT_W-1:0]    shadow_amt [NUM_CLIENTS];

  logic [CLIENT_W-1:0]    fifo_id  [DEPTH];
  logic [AMOUNT_W-1:0]    fifo_amt [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;

  logic accept;
  logic changed;
  logic push;
  logic pop;
  logic req_valid_int;

  assign bus.in_ready = (level_reg != FULL_LVL);
  assign req_valid_int = (level_reg != '0);
  assign accept  = bus.in_valid && bus.in_ready;
  // Compare uses an asynchronous table read so the decision is made in the accept cycle
  assign changed = !shadow_valid[bus.in_client_id] ||
                   (shadow_amt[bus.in_client_id] != bus.in_amount);
  assign push    = accept && changed;
  assign pop     = req_valid_int && bus.req_ready;

  assign bus.req_valid   = req_valid_int;
  assign bus.req_we      = req_valid_int;
  assign bus.req_wrindex = req_valid_int ? fifo_id[rd_ptr_reg]  : '0;
  assign bus.req_amount  = req_valid_int ? fifo_amt[rd_ptr_reg] : '0;
  assign bus.fifo_level  = level_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_shadow_valid
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow_valid[gi] <= 1'b0;
        end else if (push && (bus.in_client_id == CLIENT_W'(gi))) begin
          shadow_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      shadow_amt[bus.in_client_id] <= bus.in_amount;
      fifo_id[wr_ptr_reg]          <= bus.in_client_id;
      fifo_amt[wr_ptr_reg]         <= bus.in_amount;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    // Simultaneous push and pop leaves the occupancy untouched
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

`ifdef DS_DUP_CNT_EN
  logic [15:0] dup_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dup_cnt_reg <= '0;
    end else if (accept && !changed && (dup_cnt_reg != 16'hFFFF)) begin
      dup_cnt_reg <= dup_cnt_reg + 16'd1;
    end
  end

  assign dup_cnt = dup_cnt_reg;
`endif

endmodule

// File: tb/tb_downstream_req_gen.sv
// Self-checking bench for downstream_req_gen: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_downstream_req_gen;

  localparam int CW    = 5;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [CW-1:0] id;
    logic [AW-1:0] amt;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;

  downstream_req_gen_if #(.CLIENT_W(CW), .AMOUNT_W(AW), .DEPTH(DEPTH)) bus ();

`ifdef DS_DUP_CNT_EN
  logic [15:0] dup_cnt;
`endif

  downstream_req_gen #(.CLIENT_W(CW), .AMOUNT_W(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DS_DUP_CNT_EN
    ,
    .dup_cnt (dup_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: request queue, last-written table, duplicate count
  req_t        mq[$];
  bit          m_valid [1 << CW];
  logic [AW-1:0] m_amt [1 << CW];
  int          m_dup;
  bit          chk_en;

  int n_tests;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_dup = 0;
  endtask

  // One clock: compare outputs at negedge, then advance the model at posedge
  task automatic cycle();
    bit   acc;
    bit   pop;
    req_t head;
    @(negedge clk);
    if (chk_en) begin
      check_val("in_ready",   bus.in_ready,   32'(mq.size() != DEPTH));
      check_val("req_valid",  bus.req_valid,  32'(mq.size() != 0));
      check_val("req_we",     bus.req_we,     32'(mq.size() != 0));
      check_val("fifo_level", bus.fifo_level, 32'(mq.size()));
      if (mq.size() != 0) begin
        check_val("req_wrindex", bus.req_wrindex, 32'(mq[0].id));
        check_val("req_amount",  bus.req_amount,  32'(mq[0].amt));
      end
`ifdef DS_DUP_CNT_EN
      check_val("dup_cnt", dup_cnt, 32'(m_dup));
`endif
    end
    acc = bus.in_valid && (mq.size() != DEPTH);
    pop = (mq.size() != 0) && bus.req_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pop) begin
        head = mq.pop_front();
        $display("[TB] req issued id=%0d amt=0x%0h", head.id, head.amt);
      end
      if (acc) begin
        if (!m_valid[bus.in_client_id] || m_amt[bus.in_client_id] != bus.in_amount) begin
          mq.push_back('{id: bus.in_client_id, amt: bus.in_amount});
          m_valid[bus.in_client_id] = 1'b1;
          m_amt[bus.in_client_id]   = bus.in_amount;
        end else if (m_dup != 16'hFFFF) begin
          m_dup++;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input int id, input int amt);
    bus.in_valid     = v;
    bus.in_client_id = CW'(id);
    bus.in_amount    = AW'(amt);
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, $urandom, $urandom);
  endtask

  task automatic drain(input string tag);
    bus.req_ready = 1'b1;
    for (int k = 0; k < 20 && mq.size() != 0; k++) idle();
    idle();
    check_val(tag, bus.fifo_level, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    model_reset();
    rst_n = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_client_id = '0;
    bus.in_amount    = '0;
    bus.req_ready    = 1'b0;

    // 1. reset held for 3 cycles
    idle();
    chk_en = 1'b1;
    idle();
    idle();
    rst_n = 1'b1;
    check_val("rst_in_ready",  bus.in_ready,   1);
    check_val("rst_req_valid", bus.req_valid,  0);
    check_val("rst_level",     bus.fifo_level, 0);
    check_val("rst_wrindex",   bus.req_wrindex, 0);
    check_val("rst_amount",    bus.req_amount, 0);
`ifdef DS_DUP_CNT_EN
    check_val("rst_dup_cnt", dup_cnt, 0);
`endif
    idle();

    // 2. first write then duplicate
    bus.req_ready = 1'b1;
    drive(1'b1, 3, 16'h0010);
    check_val("t2_req_valid", bus.req_valid,   1);
    check_val("t2_wrindex",   bus.req_wrindex, 3);
    check_val("t2_amount",    bus.req_amount,  16'h0010);
    drive(1'b1, 3, 16'h0010);
    check_val("t2_level", bus.fifo_level, 0);
`ifdef DS_DUP_CNT_EN
    check_val("t2_dup_cnt", dup_cnt, 1);
`endif
    idle();

    // 3. change detect and a never-written client
    drive(1'b1, 3, 16'h0011);
    check_val("t3_amount", bus.req_amount, 16'h0011);
    drive(1'b1, 7, 16'h0010);
    check_val("t3_wrindex", bus.req_wrindex, 7);
    idle();
    idle();

    // 4. backpressure up to full, fifth update stalled
    bus.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, i, 1);
    check_val("t4_full_level", bus.fifo_level, 4);
    check_val("t4_in_ready",   bus.in_ready,   0);
    for (int i = 0; i < 3; i++) drive(1'b1, 4, 1);
    check_val("t4_head_id",  bus.req_wrindex, 0);
    check_val("t4_head_amt", bus.req_amount,  1);
    bus.req_ready = 1'b1;
    drive(1'b1, 4, 1);
    drive(1'b1, 4, 1);
    drain("t4_drained");

    // 5. steady push/pop at level 2 across pointer wrap
    bus.req_ready = 1'b0;
    drive(1'b1, 10, 16'h0100);
    drive(1'b1, 11, 16'h0101);
    bus.req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 12 + k, 16'h0200 + k);
      check_val("t5_level", bus.fifo_level, 2);
    end
    drain("t5_drained");

    // 6. reset mid-operation clears queue and shadow valid bits
    bus.req_ready = 1'b0;
    drive(1'b1, 20, 5);
    drive(1'b1, 21, 6);
    drive(1'b1, 22, 7);
    check_val("t6_level", bus.fifo_level, 3);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    check_val("t6_rst_level", bus.fifo_level, 0);
    check_val("t6_rst_valid", bus.req_valid,  0);
    drive(1'b1, 20, 5);
    check_val("t6_resend_valid", bus.req_valid,   1);
    check_val("t6_resend_idx",   bus.req_wrindex, 20);
    drain("t6_drained");

    // Random traffic over a few clients and amounts to mix changes and duplicates
    for (int k = 0; k < 600; k++) begin
      bus.req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0)
        drive(1'b1, $urandom_range(0, 3), $urandom_range(0, 2));
      else
        idle();
    end
    drain("rand_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
